wb_arbiter: RTL and testbench

- Writeback stage feeding the register_file write port (wr_en, wr_reg, wr_data).
- Merges two result sources: the single-cycle ALU path (priority) and a multi-cycle load/store unit (LSU) path buffered in a small FIFO.
- Also provides a pending-write query so decode can detect and forward values not yet in the register file.

---
 rtl/wb_arbiter_pkg.sv | 24 ++
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter.
//   XLEN        : register data width
//   REG_ADDR_W  : register index width
//   wb_entry_t  : one buffered result (valid, destination, data)
//   wb_sel_e    : which source owns the write port in a given cycle
package wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_ALU,
        SEL_DRAIN,
        SEL_BYPASS
    } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execute units, decode and the writeback arbiter.
//   slave  : arbiter side (takes ALU/LSU results and queries, drives the write port)
//   master : environment side (execute units, decode, register file)
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_stall;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_data;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [XLEN-1:0]       wr_data;
    logic [REG_ADDR_W-1:0] chk_reg;
    logic                  pend_hit;
    logic [XLEN-1:0]       pend_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, chk_reg,
        output alu_stall, lsu_ready, wr_en, wr_reg, wr_data, pend_hit, pend_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, chk_reg,
        input  alu_stall, lsu_ready, wr_en, wr_reg, wr_data, pend_hit, pend_data
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of LSU results waiting for the register file write port.
//   clk, rst          : clock, asynchronous active-high reset
//   push/push_rd/data : append an entry at the tail (caller guarantees space)
//   pop               : retire the head slot (valid or killed)
//   kill_en/kill_rd   : invalidate every valid entry targeting kill_rd
//   head, count       : head slot contents and occupancy (killed slots included)
//   rd_ptr, entries   : raw storage view for the pending-write query
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output wb_entry_t             head,
    output logic [CW-1:0]         count,
    output logic [PW-1:0]         rd_ptr,
    output wb_entry_t             entries [DEPTH]
);

    wb_entry_t     entry_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Slots outside the occupied window always hold valid=0: reset clears
    // them and a pop clears the slot it leaves, so the query and the
    // any-valid check can scan all slots without looking at count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg[gi] <= '0;
            end else if (push && wr_ptr_reg == PW'(gi)) begin
                entry_reg[gi] <= '{valid: 1'b1, rd: push_rd, data: push_data};
            end else if (pop && rd_ptr_reg == PW'(gi)) begin
                entry_reg[gi].valid <= 1'b0;
            end else if (kill_en && entry_reg[gi].valid && entry_reg[gi].rd == kill_rd) begin
                entry_reg[gi].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head    = entry_reg[rd_ptr_reg];
    assign count   = count_reg;
    assign rd_ptr  = rd_ptr_reg;
    assign entries = entry_reg;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU result (priority) with
// buffered LSU results into one registered register-file write port, and
// answers "is this register still waiting to be written?" for decode.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_arbiter_if.slave (ALU/LSU inputs, write port, stall,
//              LSU ready, pending-write query)
// DEPTH is a power of two >= 2; MAX_WAIT >= 1.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter int  MAX_WAIT = 3,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1,
    localparam int WW       = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);

    wb_entry_t             head;
    wb_entry_t             entries [DEPTH];
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;

    logic                  wr_en_reg;
    logic [REG_ADDR_W-1:0] wr_reg_reg;
    logic [XLEN-1:0]       wr_data_reg;
    logic                  alu_stall_reg;
    logic [WW-1:0]         wait_reg;
    logic [WW-1:0]         wait_next;

    wb_sel_e               sel;
    logic                  lsu_ready;
    logic                  lsu_accept;
    logic                  alu_win;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DEPTH-1:0]      valid_vec;
    logic                  any_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign valid_vec[gi] = entries[gi].valid;
    end
    assign any_valid = |valid_vec;

    // Ready looks only at the registered occupancy, never at a same-cycle pop,
    // so it has no combinational path from the ALU inputs.
    assign lsu_ready  = (count < CW'(DEPTH));
    assign lsu_accept = bus.lsu_valid & lsu_ready;
    assign alu_win    = bus.alu_valid & ~alu_stall_reg & (bus.alu_rd != '0);

    always_comb begin
        sel = SEL_IDLE;
        if (alu_win) begin
            sel = SEL_ALU;
        end else if (head.valid) begin
            sel = SEL_DRAIN;
        end else if (count == '0 && lsu_accept && bus.lsu_rd != '0) begin
            sel = SEL_BYPASS;
        end
    end

    // A killed head is discarded in the background without taking the write
    // port, so the entry behind it can drain on the next cycle.
    assign fifo_pop  = (sel == SEL_DRAIN) | ((count != '0) & ~head.valid);
    assign fifo_push = lsu_accept & (bus.lsu_rd != '0) & (sel != SEL_BYPASS);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_rd   (bus.lsu_rd),
        .push_data (bus.lsu_data),
        .pop       (fifo_pop),
        .kill_en   (sel == SEL_ALU),
        .kill_rd   (bus.alu_rd),
        .head      (head),
        .count     (count),
        .rd_ptr    (rd_ptr),
        .entries   (entries)
    );

    // Starvation counter: cycles a valid head lost the port to the ALU.
    // Once it reaches MAX_WAIT the ALU is held off, which forces a drain.
    always_comb begin
        wait_next = wait_reg;
        if (sel == SEL_DRAIN || !any_valid) begin
            wait_next = '0;
        end else if (head.valid && sel == SEL_ALU) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_reg      <= '0;
            alu_stall_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_reg_reg    <= '0;
            wr_data_reg   <= '0;
        end else begin
            wait_reg      <= wait_next;
            alu_stall_reg <= (wait_next == WW'(MAX_WAIT));
            wr_en_reg     <= (sel != SEL_IDLE);
            case (sel)
                SEL_ALU: begin
                    wr_reg_reg  <= bus.alu_rd;
                    wr_data_reg <= bus.alu_data;
                end
                SEL_DRAIN: begin
                    wr_reg_reg  <= head.rd;
                    wr_data_reg <= head.data;
                end
                SEL_BYPASS: begin
                    wr_reg_reg  <= bus.lsu_rd;
                    wr_data_reg <= bus.lsu_data;
                end
                default: ;
            endcase
        end
    end

    // Pending query. Anything still in the FIFO is younger than the value in
    // the output register (older same-rd entries were killed or already
    // drained), so scan output register first, then FIFO oldest to youngest,
    // letting each later match override.
    always_comb begin
        logic [PW-1:0] idx;
        idx           = '0;
        bus.pend_hit  = 1'b0;
        bus.pend_data = '0;
        if (bus.chk_reg != '0) begin
            if (wr_en_reg && wr_reg_reg == bus.chk_reg) begin
                bus.pend_hit  = 1'b1;
                bus.pend_data = wr_data_reg;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if (entries[idx].valid && entries[idx].rd == bus.chk_reg) begin
                    bus.pend_hit  = 1'b1;
                    bus.pend_data = entries[idx].data;
                end
            end
        end
    end

    assign bus.lsu_ready = lsu_ready;
    assign bus.alu_stall = alu_stall_reg;
    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_reg    = wr_reg_reg;
    assign bus.wr_data   = wr_data_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. A queue-based reference model is
// stepped once per cycle by the stimulus process, which pushes the expected
// visible state into a scoreboard; a negedge monitor pops and compares.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_wait;
    bit          m_stall;
    bit          m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        ready;
        logic        stall;
        logic        hit;
        logic [31:0] pdata;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wait  = 0;
        m_stall = 0;
        m_en    = 0;
        m_reg   = '0;
        m_data  = '0;
    endtask

    task automatic model_pend(input logic [4:0] chk, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (chk != 0) begin
            if (m_en && m_reg == chk) begin
                hit  = 1'b1;
                data = m_data;
            end
            foreach (mq[i]) begin
                if (mq[i].v && mq[i].rd == chk) begin
                    hit  = 1'b1;
                    data = mq[i].data;
                end
            end
        end
    endtask

    task automatic model_step(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                              input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
        bit          acc     = lv && (mq.size() < DEPTH);
        bit          alu_win = av && !m_stall && ard != 0;
        bit          hv      = mq.size() > 0 && mq[0].v;
        bit          anyv    = 0;
        bit          drain   = 0;
        bit          byp     = 0;
        bit          wr      = 0;
        logic [4:0]  nrd     = '0;
        logic [31:0] nd      = '0;
        foreach (mq[i]) anyv |= mq[i].v;
        if (alu_win) begin
            wr = 1; nrd = ard; nd = adata;
        end else if (hv) begin
            wr = 1; drain = 1; nrd = mq[0].rd; nd = mq[0].data;
        end else if (mq.size() == 0 && acc && lrd != 0) begin
            wr = 1; byp = 1; nrd = lrd; nd = ldata;
        end
        if (mq.size() > 0 && (drain || !hv)) void'(mq.pop_front());
        if (alu_win) begin
            foreach (mq[i]) if (mq[i].rd == ard) mq[i].v = 0;
        end
        if (acc && lrd != 0 && !byp) mq.push_back('{v: 1'b1, rd: lrd, data: ldata});
        if (drain || !anyv)       m_wait = 0;
        else if (hv && alu_win)   m_wait++;
        m_stall = (m_wait == MAX_WAIT);
        m_en    = wr;
        if (wr) begin
            m_reg  = nrd;
            m_data = nd;
        end
    endtask

    // One cycle of stimulus: apply inputs, record what must be visible this
    // cycle, then advance the model to the next cycle.
    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ldata,
                         input logic [4:0] chk);
        exp_t e;
        @(posedge clk);
        #1;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adata;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ldata;
        bus.chk_reg   = chk;
        e.en    = m_en;
        e.rg    = m_reg;
        e.data  = m_data;
        e.ready = (mq.size() < DEPTH);
        e.stall = m_stall;
        model_pend(chk, e.hit, e.pdata);
        exp_q.push_back(e);
        model_step(av, ard, adata, lv, lrd, ldata);
    endtask

    task automatic idle(input logic [4:0] chk);
        drive(0, 0, 0, 0, 0, 0, chk);
    endtask

    // Asynchronous reset in the middle of a cycle: outputs must clear at once.
    task automatic reset_mid(input logic [4:0] chk);
        @(posedge clk);
        #1;
        bus.alu_valid = 0;
        bus.lsu_valid = 0;
        bus.chk_reg   = chk;
        #1 rst = 1'b1;
        #1;
        check("rst_wr_en",     32'(bus.wr_en),     0);
        check("rst_wr_reg",    32'(bus.wr_reg),    0);
        check("rst_wr_data",   bus.wr_data,        0);
        check("rst_alu_stall", 32'(bus.alu_stall), 0);
        check("rst_pend_hit",  32'(bus.pend_hit),  0);
        check("rst_pend_data", bus.pend_data,      0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("wr_en",     32'(bus.wr_en),     32'(mon_e.en));
            check("wr_reg",    32'(bus.wr_reg),    32'(mon_e.rg));
            check("wr_data",   bus.wr_data,        mon_e.data);
            check("lsu_ready", 32'(bus.lsu_ready), 32'(mon_e.ready));
            check("alu_stall", 32'(bus.alu_stall), 32'(mon_e.stall));
            check("pend_hit",  32'(bus.pend_hit),  32'(mon_e.hit));
            check("pend_data", bus.pend_data,      mon_e.pdata);
            if (bus.wr_en)
                $display("wr x%0d <= 0x%08h", bus.wr_reg, bus.wr_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    int pa[4] = '{50, 90, 10, 95};
    int pl[4] = '{50, 60, 80, 70};

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.chk_reg   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_wr_en",     32'(bus.wr_en),     0);
        check("reset_wr_data",   bus.wr_data,        0);
        check("reset_alu_stall", 32'(bus.alu_stall), 0);
        rst = 1'b0;

        // ALU write, one-cycle latency then idle
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5);
        idle(5);
        idle(5);
        // bypass with empty FIFO
        drive(0, 0, 0, 1, 7, 32'h1234, 7);
        idle(7);
        idle(7);
        // starvation: ALU every cycle, one LSU result waiting
        for (int i = 0; i < 8; i++)
            drive(1, 1, 32'(i), i == 0, 9, 32'hAA, 9);
        idle(9);
        // kill of an older buffered result by a younger ALU write
        drive(1, 3, 32'h33, 1, 12, 32'h11, 12);
        drive(1, 12, 32'h22, 0, 0, 0, 12);
        idle(12);
        idle(12);
        idle(12);
        // fill the FIFO under constant ALU, then reset mid-drain
        for (int i = 0; i < 6; i++)
            drive(1, 2, 32'(i), 1, 5'(20 + i), 32'(100 + i), 5'(20 + i % 2));
        reset_mid(21);
        idle(21);
        // x0 on both sources
        for (int i = 0; i < 3; i++)
            drive(1, 0, 32'hFFFF, 1, 0, 32'hEEEE, 0);
        idle(0);

        // randomized phases with different traffic mixes
        for (int ph = 0; ph < 12; ph++) begin
            int mode = ph % 4;
            int rmax = (mode == 3) ? 3 : 7;
            if (ph == 6) reset_mid(5'($urandom_range(1, 7)));
            for (int c = 0; c < 150; c++) begin
                bit         av  = ($urandom_range(0, 99) < pa[mode]);
                bit         lv  = ($urandom_range(0, 99) < pl[mode]);
                logic [4:0] ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, rmax));
                logic [4:0] lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, rmax));
                drive(av, ard, $urandom, lv, lrd, $urandom, 5'($urandom_range(0, rmax)));
            end
        end

        idle(0);
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0)
            check("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
